// File: rtl/reg_file_if.sv
// Issue/commit, operand-query and ROB-lookup signals of the architectural
// register file. The master side is the ROB/decoder, the slave side is reg_file.
interface reg_file_if #(
  parameter int ROB_BIT = 4
);
  // ROB issue/commit
  logic               clear_up;
  logic               issue_valid;
  logic [4:0]         issue_reg_id;
  logic [ROB_BIT-1:0] issue_rob_entry;
  logic               commit_valid;
  logic [4:0]         commit_rd_reg_id;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic [31:0]        commit_value;

  // Decoder operand queries
  logic [4:0]         rs1_id;
  logic [4:0]         rs2_id;
  logic               rs1_ready;
  logic               rs2_ready;
  logic [31:0]        rs1_value;
  logic [31:0]        rs2_value;
  logic [ROB_BIT-1:0] rs1_rob_entry;
  logic [ROB_BIT-1:0] rs2_rob_entry;

  // ROB lookup port for renamed sources
  logic [ROB_BIT-1:0] get_rob_entry1;
  logic [ROB_BIT-1:0] get_rob_entry2;
  logic               rob_ready1;
  logic               rob_ready2;
  logic [31:0]        rob_value1;
  logic [31:0]        rob_value2;

  modport master (
    output clear_up, issue_valid, issue_reg_id, issue_rob_entry,
    output commit_valid, commit_rd_reg_id, commit_rob_entry, commit_value,
    output rs1_id, rs2_id, rob_ready1, rob_ready2, rob_value1, rob_value2,
    input  rs1_ready, rs2_ready, rs1_value, rs2_value,
    input  rs1_rob_entry, rs2_rob_entry, get_rob_entry1, get_rob_entry2
  );

  modport slave (
    input  clear_up, issue_valid, issue_reg_id, issue_rob_entry,
    input  commit_valid, commit_rd_reg_id, commit_rob_entry, commit_value,
    input  rs1_id, rs2_id, rob_ready1, rob_ready2, rob_value1, rob_value2,
    output rs1_ready, rs2_ready, rs1_value, rs2_value,
    output rs1_rob_entry, rs2_rob_entry, get_rob_entry1, get_rob_entry2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags. Values retire
// from the ROB at commit; sources resolve combinationally from local state,
// the commit bypass, or the ROB lookup port. x0 is hard-wired to zero.
module reg_file #(
  parameter int ROB_BIT = 4,
  parameter int REG_NUM = 32
) (
  input logic          clk_in,
  input logic          rst_in,
  input logic          rdy_in,
  reg_file_if.slave    bus
);

  typedef struct packed {
    logic               ready;
    logic [31:0]        value;
    logic [ROB_BIT-1:0] entry;
  } lookup_t;

  logic [31:0]        value_q [REG_NUM];
  logic               busy_q  [REG_NUM];
  logic [ROB_BIT-1:0] tag_q   [REG_NUM];

  lookup_t rs1_res;
  lookup_t rs2_res;

  // Register state: commit writes the value; busy/tag follow commit-clear,
  // then flush, then issue, so a same-cycle issue overrides a commit-clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (bus.commit_valid && bus.commit_rd_reg_id != 5'd0) begin
        value_q[bus.commit_rd_reg_id] <= bus.commit_value;
        if (busy_q[bus.commit_rd_reg_id] &&
            tag_q[bus.commit_rd_reg_id] == bus.commit_rob_entry) begin
          busy_q[bus.commit_rd_reg_id] <= 1'b0;
        end
      end
      if (bus.clear_up) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          busy_q[i] <= 1'b0;
          tag_q[i]  <= '0;
        end
      end else if (bus.issue_valid && bus.issue_reg_id != 5'd0) begin
        busy_q[bus.issue_reg_id] <= 1'b1;
        tag_q[bus.issue_reg_id]  <= bus.issue_rob_entry;
      end
    end
  end

  function automatic lookup_t resolve(
    input logic [4:0]         id,
    input logic               busy,
    input logic [ROB_BIT-1:0] tag,
    input logic [31:0]        val,
    input logic               rob_rdy,
    input logic [31:0]        rob_val,
    input logic               c_valid,
    input logic [4:0]         c_rd,
    input logic [ROB_BIT-1:0] c_entry,
    input logic [31:0]        c_value
  );
    lookup_t r;
    r = '0;
    if (id == 5'd0) begin
      r.ready = 1'b1;
    end else if (!busy) begin
      r.ready = 1'b1;
      r.value = val;
    end else if (c_valid && c_rd == id && c_entry == tag) begin
      r.ready = 1'b1;
      r.value = c_value;
    end else if (rob_rdy) begin
      r.ready = 1'b1;
      r.value = rob_val;
    end else begin
      r.entry = tag;
    end
    return r;
  endfunction

  // Source 1 resolution
  always_comb begin
    rs1_res = resolve(bus.rs1_id, busy_q[bus.rs1_id], tag_q[bus.rs1_id],
                      value_q[bus.rs1_id], bus.rob_ready1, bus.rob_value1,
                      bus.commit_valid, bus.commit_rd_reg_id,
                      bus.commit_rob_entry, bus.commit_value);
  end

  // Source 2 resolution
  always_comb begin
    rs2_res = resolve(bus.rs2_id, busy_q[bus.rs2_id], tag_q[bus.rs2_id],
                      value_q[bus.rs2_id], bus.rob_ready2, bus.rob_value2,
                      bus.commit_valid, bus.commit_rd_reg_id,
                      bus.commit_rob_entry, bus.commit_value);
  end

  assign bus.rs1_ready      = rs1_res.ready;
  assign bus.rs1_value      = rs1_res.value;
  assign bus.rs1_rob_entry  = rs1_res.entry;
  assign bus.rs2_ready      = rs2_res.ready;
  assign bus.rs2_value      = rs2_res.value;
  assign bus.rs2_rob_entry  = rs2_res.entry;
  // tag_q[0] is never written, so x0 always looks up tag 0
  assign bus.get_rob_entry1 = tag_q[bus.rs1_id];
  assign bus.get_rob_entry2 = tag_q[bus.rs2_id];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-based model.
module tb_reg_file;

  localparam int RB = 4;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  reg_file_if #(.ROB_BIT(RB)) bus ();

  reg_file #(.ROB_BIT(RB), .REG_NUM(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Reference state
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RB-1:0] m_tag  [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected operand for one source, from the lookup priority rules
  task automatic expect_src(input logic [4:0] id, input logic rr, input logic [31:0] rv,
                            output logic rdy, output logic [31:0] val, output logic [RB-1:0] ent);
    rdy = 1'b0; val = '0; ent = '0;
    if (id == 0) rdy = 1'b1;
    else if (!m_busy[id]) begin rdy = 1'b1; val = m_val[id]; end
    else if (bus.commit_valid && bus.commit_rd_reg_id == id && bus.commit_rob_entry == m_tag[id]) begin
      rdy = 1'b1; val = bus.commit_value;
    end else if (rr) begin rdy = 1'b1; val = rv; end
    else ent = m_tag[id];
  endtask

  // Model state update on each rising edge
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      if (bus.commit_valid && bus.commit_rd_reg_id != 0) begin
        m_val[bus.commit_rd_reg_id] = bus.commit_value;
        if (m_busy[bus.commit_rd_reg_id] && m_tag[bus.commit_rd_reg_id] == bus.commit_rob_entry)
          m_busy[bus.commit_rd_reg_id] = 1'b0;
      end
      if (bus.clear_up) begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
      end else if (bus.issue_valid && bus.issue_reg_id != 0) begin
        m_busy[bus.issue_reg_id] = 1'b1;
        m_tag[bus.issue_reg_id]  = bus.issue_rob_entry;
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  always @(negedge clk_in) begin
    logic r1, r2;
    logic [31:0] v1, v2;
    logic [RB-1:0] e1, e2;
    if (model_on) begin
      expect_src(bus.rs1_id, bus.rob_ready1, bus.rob_value1, r1, v1, e1);
      expect_src(bus.rs2_id, bus.rob_ready2, bus.rob_value2, r2, v2, e2);
      check("m_rs1_ready", 32'(bus.rs1_ready), 32'(r1));
      check("m_rs1_value", bus.rs1_value, v1);
      check("m_rs1_entry", 32'(bus.rs1_rob_entry), 32'(e1));
      check("m_get1", 32'(bus.get_rob_entry1), 32'(m_tag[bus.rs1_id]));
      check("m_rs2_ready", 32'(bus.rs2_ready), 32'(r2));
      check("m_rs2_value", bus.rs2_value, v2);
      check("m_rs2_entry", 32'(bus.rs2_rob_entry), 32'(e2));
      check("m_get2", 32'(bus.get_rob_entry2), 32'(m_tag[bus.rs2_id]));
    end
  end

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1;
    bus.clear_up = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_reg_id = '0; bus.issue_rob_entry = '0;
    bus.commit_valid = 1'b0; bus.commit_rd_reg_id = '0; bus.commit_rob_entry = '0;
    bus.commit_value = '0;
    bus.rs1_id = '0; bus.rs2_id = '0;
    bus.rob_ready1 = 1'b0; bus.rob_ready2 = 1'b0;
    bus.rob_value1 = '0; bus.rob_value2 = '0;
  endtask

  // Advance one edge and return to idle inputs just after it
  task automatic tick();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    rdy_in = 1'b0;
    tick();
    model_on = 1'b1;

    // Reset state
    bus.rs1_id = 5; bus.rs2_id = 0;
    #1;
    check("rst_rs1_ready", 32'(bus.rs1_ready), 1);
    check("rst_rs1_value", bus.rs1_value, 0);
    check("rst_rs1_entry", 32'(bus.rs1_rob_entry), 0);
    check("rst_rs2_ready", 32'(bus.rs2_ready), 1);
    check("rst_rs2_value", bus.rs2_value, 0);
    check("rst_get2", 32'(bus.get_rob_entry2), 0);
    tick();

    // Issue x5 tag 3, then query via ROB
    bus.issue_valid = 1; bus.issue_reg_id = 5; bus.issue_rob_entry = 3;
    tick();
    bus.rs1_id = 5;
    #1;
    check("busy_ready", 32'(bus.rs1_ready), 0);
    check("busy_entry", 32'(bus.rs1_rob_entry), 3);
    check("busy_get1", 32'(bus.get_rob_entry1), 3);
    bus.rob_ready1 = 1; bus.rob_value1 = 32'hDEAD;
    #1;
    check("rob_fwd_ready", 32'(bus.rs1_ready), 1);
    check("rob_fwd_value", bus.rs1_value, 32'hDEAD);
    check("rob_fwd_entry", 32'(bus.rs1_rob_entry), 0);
    tick();

    // Commit bypass then retired value
    bus.rs1_id = 5;
    bus.commit_valid = 1; bus.commit_rd_reg_id = 5; bus.commit_rob_entry = 3;
    bus.commit_value = 32'h1234;
    #1;
    check("byp_ready", 32'(bus.rs1_ready), 1);
    check("byp_value", bus.rs1_value, 32'h1234);
    tick();
    bus.rs1_id = 5;
    #1;
    check("ret_ready", 32'(bus.rs1_ready), 1);
    check("ret_value", bus.rs1_value, 32'h1234);
    tick();

    // Stale commit: rename 3 then 7, commit 3
    bus.issue_valid = 1; bus.issue_reg_id = 5; bus.issue_rob_entry = 3;
    tick();
    bus.issue_valid = 1; bus.issue_reg_id = 5; bus.issue_rob_entry = 7;
    tick();
    bus.commit_valid = 1; bus.commit_rd_reg_id = 5; bus.commit_rob_entry = 3;
    bus.commit_value = 32'h11;
    tick();
    bus.rs1_id = 5;
    #1;
    check("stale_ready", 32'(bus.rs1_ready), 0);
    check("stale_entry", 32'(bus.rs1_rob_entry), 7);
    tick();

    // Same-cycle issue and stale commit on x6
    bus.issue_valid = 1; bus.issue_reg_id = 6; bus.issue_rob_entry = 1;
    tick();
    bus.issue_valid = 1; bus.issue_reg_id = 6; bus.issue_rob_entry = 2;
    bus.commit_valid = 1; bus.commit_rd_reg_id = 6; bus.commit_rob_entry = 1;
    bus.commit_value = 32'h55;
    tick();
    bus.rs1_id = 6;
    #1;
    check("iss_com_ready", 32'(bus.rs1_ready), 0);
    check("iss_com_entry", 32'(bus.rs1_rob_entry), 2);
    tick();

    // Flush with simultaneous issue of x7
    bus.clear_up = 1; bus.issue_valid = 1; bus.issue_reg_id = 7; bus.issue_rob_entry = 4;
    tick();
    bus.rs1_id = 5; bus.rs2_id = 6;
    #1;
    check("flush_x5_ready", 32'(bus.rs1_ready), 1);
    check("flush_x5_value", bus.rs1_value, 32'h11);
    check("flush_x6_ready", 32'(bus.rs2_ready), 1);
    check("flush_x6_value", bus.rs2_value, 32'h55);
    bus.rs1_id = 7;
    #1;
    check("flush_x7_ready", 32'(bus.rs1_ready), 1);
    check("flush_x7_get1", 32'(bus.get_rob_entry1), 0);
    tick();

    // Stalled issue of x8
    rdy_in = 0; bus.issue_valid = 1; bus.issue_reg_id = 8; bus.issue_rob_entry = 5;
    tick();
    bus.rs1_id = 8;
    #1;
    check("stall_ready", 32'(bus.rs1_ready), 1);
    check("stall_entry", 32'(bus.get_rob_entry1), 0);
    tick();

    // x0 is never renamed
    bus.issue_valid = 1; bus.issue_reg_id = 0; bus.issue_rob_entry = 9;
    bus.commit_valid = 1; bus.commit_rd_reg_id = 0; bus.commit_value = 32'hFFFF;
    tick();
    bus.rs1_id = 0;
    #1;
    check("x0_value", bus.rs1_value, 0);
    check("x0_get1", 32'(bus.get_rob_entry1), 0);
    tick();

    // Randomized traffic, checked by the per-cycle compare
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rd;
      rst_in = ($urandom % 300) == 0;
      rdy_in = ($urandom % 8) != 0;
      bus.clear_up = ($urandom % 30) == 0;
      bus.issue_valid = $urandom % 2;
      bus.issue_reg_id = 5'($urandom % 10);
      bus.issue_rob_entry = RB'($urandom);
      rd = 5'($urandom % 10);
      bus.commit_valid = $urandom % 2;
      bus.commit_rd_reg_id = rd;
      bus.commit_rob_entry = (($urandom % 3) == 0) ? RB'($urandom) : m_tag[rd];
      bus.commit_value = $urandom;
      bus.rs1_id = 5'($urandom % 10);
      bus.rs2_id = (($urandom % 2) == 0) ? rd : 5'($urandom % 10);
      bus.rob_ready1 = ($urandom % 3) == 0;
      bus.rob_ready2 = ($urandom % 3) == 0;
      bus.rob_value1 = $urandom;
      bus.rob_value2 = $urandom;
      @(posedge clk_in);
      #1;
    end
    idle();
    @(negedge clk_in);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags for the Tomasulo RISC-V core.
- It is the consumer end of the ROB issue/commit interface:
  - the ROB marks a destination register as renamed at issue;
  - the ROB retires the value into the register at commit.
- It resolves source operands for the decoder. When a source is still renamed, it queries the ROB through the get_rob_entry/ready/value lookup port.

Parameters:
- ROB_BIT, 4, width of a ROB entry index (ROB_SIZE = 2^ROB_BIT).
- REG_NUM, 32, number of architectural registers. Register x0 is hard-wired to zero.

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge
- rst_in  input  1  synchronous reset, active-high
- rdy_in  input  1  ready; when low, all state holds
- clear_up  input  1  misprediction flush from the ROB
- issue_valid  input  1  ROB issue: rename a destination register
- issue_reg_id  input  5  destination register being renamed
- issue_rob_entry  input  ROB_BIT  ROB tag assigned to that register
- commit_valid  input  1  ROB commit of a register-writing instruction
- commit_rd_reg_id  input  5  destination register of the committing instruction
- commit_rob_entry  input  ROB_BIT  ROB tag of the committing instruction
- commit_value  input  32  value being retired
- rs1_id, rs2_id  input  5 each  source registers queried by the decoder
- rs1_ready, rs2_ready  output  1 each  1 = operand value is valid now
- rs1_value, rs2_value  output  32 each  operand value; 0 when not ready
- rs1_rob_entry, rs2_rob_entry  output  ROB_BIT each  producer tag when not ready, else 0
- get_rob_entry1, get_rob_entry2  output  ROB_BIT each  tag looked up in the ROB
- rob_ready1, rob_ready2  input  1 each  ROB reports the looked-up tag's result is available
- rob_value1, rob_value2  input  32 each  ROB value for the looked-up tag

Behaviour:
- State per register i:
  - value[i], 32 bits;
  - busy[i], 1 bit;
  - tag[i], ROB_BIT bits.
- Reset (rst_in=1 at a clock edge, regardless of rdy_in): all value, busy and tag bits are cleared to 0. Outputs are combinational from state, so after reset every query returns ready=1, value=0, rob_entry=0.
- rdy_in=0 and no reset: no state changes. Combinational outputs remain live.
- Commit (commit_valid=1, rdy_in=1, commit_rd_reg_id≠0):
  - value[rd] <= commit_value, unconditionally. In-order commit guarantees it is the newest retired value.
  - busy[rd] is cleared only if busy[rd]=1 and tag[rd]=commit_rob_entry. A stale tag leaves busy and tag unchanged.
- Issue (issue_valid=1, rdy_in=1, clear_up=0, issue_reg_id≠0): busy[rd] <= 1 and tag[rd] <= issue_rob_entry.
- Issue and commit in the same cycle to the same register:
  - issue wins for busy and tag (busy stays 1, tag becomes the new entry);
  - commit still writes value.
- Flush (clear_up=1, rdy_in=1):
  - all busy and tag bits are cleared to 0;
  - a commit in the same cycle still writes value;
  - an issue in the same cycle is ignored.
- x0: writes and renames are discarded. A query of x0 always returns ready=1, value=0, rob_entry=0, and get_rob_entry=0.
- Operand lookup is purely combinational, zero latency. It evaluates in priority order, shown here for rs1 (rs2 is identical, using port 2):
  1. rs1_id=0: ready=1, value=0.
  2. Else if busy=0: ready=1, value=value[rs1].
  3. Else if commit_valid=1, commit_rd_reg_id=rs1 and commit_rob_entry=tag[rs1]: ready=1, value=commit_value (commit bypass).
  4. Else if rob_ready1=1: ready=1, value=rob_value1 (ROB or broadcast forward).
  5. Else: ready=0, value=0, rs1_rob_entry=tag[rs1].
- get_rob_entry1 = tag[rs1_id] at all times (0 for x0). It is driven whether or not the register is busy.
- rs1_rob_entry is nonzero only in the not-ready case.
- A same-cycle issue does not affect the lookup. The lookup reflects state before the edge, so an instruction reading its own destination sees the old producer.
- No internal FSM beyond the per-register busy/tag state. The ROB guarantees at most one issue and one commit per cycle.

Test Plan:
- Reset, then query rs1=5 and rs2=0 -> both ready=1, value=0, rob_entry=0.
- Issue x5 with tag 3; next cycle query x5 with rob_ready1=0 -> ready=0, rs1_rob_entry=3, get_rob_entry1=3. Then set rob_ready1=1, rob_value1=0xDEAD -> ready=1, value=0xDEAD.
- x5 busy with tag 3; commit x5, tag 3, value 0x1234 -> same cycle bypass gives ready=1, value=0x1234; next cycle busy=0, value=0x1234.
- x5 renamed to tag 3, then to tag 7; commit tag 3, value 0x11 -> value[5]=0x11, busy stays 1, tag stays 7.
- Same cycle: issue x6 with tag 2 and commit x6 with its old tag 1, value 0x55 -> value=0x55, busy=1, tag=2.
- Flush with x5/x6 busy and a simultaneous issue x7 with tag 4 -> all registers ready next cycle, x7 not busy. Then hold rdy_in=0 and issue x8 -> x8 remains not busy.
